// File: rtl/clock_divider.sv
// Integer clock divider producing a 50% duty square wave for even and odd ratios.
// Odd ratios stretch the high phase by half a clock with a falling-edge register.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-low reset (0 = reset asserted)
//   outclk - divided clock, period DIVIDE clk periods, 50% duty
module clock_divider #(
   parameter int unsigned DIVIDE = 4
) (
   input  logic clk,
   input  logic rst,
   output logic outclk
);

   localparam int unsigned CW     = (DIVIDE <= 2) ? 1 : $clog2(DIVIDE);
   localparam int unsigned THRESH = DIVIDE - DIVIDE / 2;
   localparam bit          ODD    = (DIVIDE % 2) == 1;

   // Reject ratios outside the supported range at elaboration
   if (DIVIDE < 2 || DIVIDE > 65535) begin : g_bad_divide
      $error("clock_divider: DIVIDE=%0d outside legal range 2..65535", DIVIDE);
   end

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          pos_q;

   // Modulo-DIVIDE count; wraps explicitly so non-power-of-2 ratios never alias
   always_comb begin
      cnt_next = cnt + CW'(1);
      if (cnt == CW'(DIVIDE - 1)) begin
         cnt_next = '0;
      end
   end

   // Counter and rising-edge phase register; pos_q is high for the upper part of the count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         pos_q <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         pos_q <= (cnt_next >= CW'(THRESH));
      end
   end

   if (ODD) begin : g_odd
      logic neg_q;

      // Half-cycle delayed copy extends the high phase to exactly DIVIDE/2 clocks
      always_ff @(negedge clk or negedge rst) begin
         if (!rst) begin
            neg_q <= 1'b0;
         end else begin
            neg_q <= pos_q;
         end
      end

      // OR of two registers: rises with pos_q, falls with neg_q, no clk in the path
      assign outclk = pos_q | neg_q;
   end else begin : g_even
      assign outclk = pos_q;
   end

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: several ratios share one clock and reset;
// each output is compared every half clock against a waveform model derived from
// the start latency and the 50% duty rule.
module tb_clock_divider;
   timeunit 1ns;
   timeprecision 10ps;

   localparam int unsigned N = 5;
   localparam int unsigned DIVS [N] = '{2, 3, 4, 5, 10};

   logic         clk;
   logic         rst;
   logic [N-1:0] oc;

   int checks;
   int errors;
   int p;            // half-cycle index since release; rising edge k has p == 2k
   bit running;
   int rises [N];
   logic [N-1:0] prev;

   for (genvar g = 0; g < N; g++) begin : g_dut
      clock_divider #(.DIVIDE(DIVS[g])) u_dut (
         .clk    (clk),
         .rst    (rst),
         .outclk (oc[g])
      );
   end

   // Expected level: first rise at edge T, then high D half-cycles, low D half-cycles
   function automatic logic model_out(input int unsigned d, input int ph);
      int t;
      int q;
      t = int'(d - d / 2);
      q = ph - 2 * t;
      if (q < 0) return 1'b0;
      return (q % (2 * int'(d))) < int'(d);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s d=%0d p=%0d", tag, DIVS[i], p), 32'(oc[i]),
               running ? 32'(model_out(DIVS[i], p)) : 32'd0);
      end
   endtask

   // One clock toggle, sampled a quarter cycle after the edge
   task automatic half_step(input string tag);
      #0.5 clk = ~clk;
      if (running) p++;
      #0.25;
      check_all(tag);
      for (int i = 0; i < N; i++) begin
         if (oc[i] && !prev[i]) rises[i]++;
      end
      prev = oc;
      #0.25;
   endtask

   task automatic release_rst();
      rst     = 1'b1;
      running = 1'b1;
      p       = clk ? 0 : 1;
      prev    = '0;
      for (int i = 0; i < N; i++) rises[i] = 0;
   endtask

   task automatic assert_rst(input string tag);
      rst     = 1'b0;
      running = 1'b0;
      #0.1;
      check_all(tag);
   endtask

   initial begin
      int unsigned n;
      int          bound;
      checks  = 0;
      errors  = 0;
      running = 1'b0;
      p       = 0;
      prev    = '0;
      clk     = 1'b0;
      rst     = 1'b1;

      // Reset with clock stopped: outputs low and X-free throughout
      #1 assert_rst("rst_assert");
      repeat (10) begin
         #10;
         check_all("rst_hold_stopped");
      end

      // 1000 clock cycles from release: waveform every half cycle and rise counts
      release_rst();
      repeat (2000) half_step("wave_long");
      for (int i = 0; i < N; i++) begin
         int t;
         t = int'(DIVS[i] - DIVS[i] / 2);
         check($sformatf("rises_1000 d=%0d", DIVS[i]), 32'(rises[i]),
               32'((1000 - t) / int'(DIVS[i]) + 1));
      end

      // Reset in the middle of a DIVIDE=4 high phase
      bound = 0;
      while (oc[2] !== 1'b1 && bound < 20) begin
         half_step("seek_high");
         bound++;
      end
      check("seek_high_bound", 32'(oc[2]), 32'd1);
      assert_rst("rst_mid_high");
      repeat (5) begin
         #1;
         check_all("rst_hold_mid");
      end
      release_rst();
      repeat (40) half_step("wave_restart");

      // Random reset/run episodes, with the release landing on either clock phase
      repeat (30) begin
         assert_rst("rst_rand");
         n = $urandom_range(0, 5);
         repeat (n) half_step("rst_hold_rand");
         release_rst();
         n = $urandom_range(1, 300);
         repeat (n) half_step("wave_rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
